// File: rtl/xbar_wrr_prio_ctrl_pkg.sv
// xbar_wrr_prio_ctrl_pkg: shared defaults, index/weight types and weight helper for the WRR scheduler
package xbar_wrr_prio_ctrl_pkg;
  localparam int DefNumIn = 4;
  localparam int DefNumOut = 4;
  localparam int DefWeightWidth = 4;
  localparam int DefNumInLog = (DefNumIn == 1) ? 1 : $clog2(DefNumIn);
  typedef logic [DefNumInLog-1:0] ini_idx_t;
  typedef logic [DefWeightWidth-1:0] weight_t;
  function automatic int unsigned eff_weight(input int unsigned w);
    return (w == 0) ? 1 : w;
  endfunction
endpackage

// File: rtl/xbar_wrr_prio_ctrl_if.sv
// xbar_wrr_prio_ctrl_if: enable, config, monitor and priority-output bundle of the WRR scheduler
interface xbar_wrr_prio_ctrl_if
  import xbar_wrr_prio_ctrl_pkg::*;
#(
  parameter int NumIn = DefNumIn,
  parameter int NumOut = DefNumOut,
  parameter int WeightWidth = DefWeightWidth
) ();
  localparam int NumInLog = (NumIn == 1) ? 1 : $clog2(NumIn);
  logic en_i;
  logic cfg_valid_i;
  logic [NumInLog-1:0] cfg_idx_i;
  logic [WeightWidth-1:0] cfg_weight_i;
  logic [NumOut-1:0] mon_valid_i;
  logic [NumOut-1:0] mon_ready_i;
  logic [NumOut-1:0][NumInLog-1:0] mon_ini_i;
  logic [NumOut-1:0][NumInLog-1:0] rr_o;
  logic [NumOut-1:0][WeightWidth-1:0] credit_o;
  modport master (output en_i, cfg_valid_i, cfg_idx_i, cfg_weight_i, mon_valid_i, mon_ready_i, mon_ini_i,
                  input rr_o, credit_o);
  modport slave (input en_i, cfg_valid_i, cfg_idx_i, cfg_weight_i, mon_valid_i, mon_ready_i, mon_ini_i,
                 output rr_o, credit_o);
endinterface

// File: rtl/xbar_wrr_prio_ctrl_ptr.sv
// xbar_wrr_prio_ctrl_ptr: per-target priority pointer and credit counter with weighted rotation
module xbar_wrr_prio_ctrl_ptr
  import xbar_wrr_prio_ctrl_pkg::*;
#(
  parameter int NumIn = DefNumIn,
  parameter int WeightWidth = DefWeightWidth,
  parameter int NumInLog = (NumIn == 1) ? 1 : $clog2(NumIn)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              grant_i,
  input  logic [NumInLog-1:0]               g_i,
  input  logic [NumIn-1:0][WeightWidth-1:0] weight_i,
  output logic [NumInLog-1:0]               ptr_o,
  output logic [WeightWidth-1:0]            credit_o
);
  logic [NumInLog-1:0] ptr_q, ptr_d, nxt_p, nxt_g;
  logic [WeightWidth-1:0] credit_q, credit_d, w_g, w_np, w_ng;
  logic fire, hold;
  always_comb begin
    nxt_p = (32'(ptr_q) == NumIn - 1) ? '0 : ptr_q + 1'b1;
    nxt_g = (32'(g_i) == NumIn - 1) ? '0 : g_i + 1'b1;
    w_g = WeightWidth'(eff_weight(32'(weight_i[g_i])));
    w_np = WeightWidth'(eff_weight(32'(weight_i[nxt_p])));
    w_ng = WeightWidth'(eff_weight(32'(weight_i[nxt_g])));
    fire = grant_i && (32'(g_i) < NumIn);
    hold = (g_i == ptr_q);
    ptr_d = !fire ? ptr_q : hold ? ((credit_q > 1) ? ptr_q : nxt_p) : ((w_g > 1) ? g_i : nxt_g);
    credit_d = !fire ? credit_q : hold ? ((credit_q > 1) ? credit_q - 1'b1 : w_np)
                                       : ((w_g > 1) ? w_g - 1'b1 : w_ng);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      credit_q <= WeightWidth'(1);
    end else begin
      ptr_q <= ptr_d;
      credit_q <= credit_d;
    end
  end
  assign ptr_o = ptr_q;
  assign credit_o = credit_q;
  assert property (@(posedge clk_i) NumIn > 0 && WeightWidth > 0);
  assert property (@(posedge clk_i) disable iff (!rst_ni) grant_i |-> 32'(g_i) < NumIn);
endmodule

// File: rtl/xbar_wrr_prio_ctrl.sv
// xbar_wrr_prio_ctrl: weighted round-robin priority scheduler driving the crossbar's per-target rr index
module xbar_wrr_prio_ctrl
  import xbar_wrr_prio_ctrl_pkg::*;
#(
  parameter int NumIn = DefNumIn,
  parameter int NumOut = DefNumOut,
  parameter int WeightWidth = DefWeightWidth,
  localparam int NumInLog = (NumIn == 1) ? 1 : $clog2(NumIn)
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  xbar_wrr_prio_ctrl_if.slave  bus
);
  logic [NumIn-1:0][WeightWidth-1:0] weight_q, weight_d;
  always_comb begin
    for (int i = 0; i < NumIn; i++)
      weight_d[i] = (bus.cfg_valid_i && 32'(bus.cfg_idx_i) == i) ? bus.cfg_weight_i : weight_q[i];
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) weight_q <= {NumIn{WeightWidth'(1)}};
    else weight_q <= weight_d;
  end
  for (genvar k = 0; k < NumOut; k++) begin : g_tgt
    xbar_wrr_prio_ctrl_ptr #(
      .NumIn(NumIn),
      .WeightWidth(WeightWidth),
      .NumInLog(NumInLog)
    ) u_ptr (
      .clk_i(clk_i),
      .rst_ni(rst_ni),
      .grant_i(bus.mon_valid_i[k] & bus.mon_ready_i[k] & bus.en_i),
      .g_i(bus.mon_ini_i[k]),
      .weight_i(weight_q),
      .ptr_o(bus.rr_o[k]),
      .credit_o(bus.credit_o[k])
    );
  end
  assert property (@(posedge clk_i) NumOut > 0);
endmodule

// File: tb/tb_xbar_wrr_prio_ctrl.sv
// tb_xbar_wrr_prio_ctrl: random and directed checking of the WRR scheduler against a behavioural model
module tb_xbar_wrr_prio_ctrl;
  import xbar_wrr_prio_ctrl_pkg::*;
  logic clk_i = 0, rst_ni = 0;
  always #5 clk_i = ~clk_i;
  logic en, cv;
  logic [1:0] ci;
  logic [3:0] cw, mv, mr;
  logic [3:0][1:0] mi4, mi3;
  int errs = 0, checks = 0;
  bit chk_on = 0;
  int m_ptr[2][4], m_cr[2][4], m_w[2][4];
  xbar_wrr_prio_ctrl_if #(.NumIn(4), .NumOut(4), .WeightWidth(4)) i4 ();
  xbar_wrr_prio_ctrl_if #(.NumIn(3), .NumOut(4), .WeightWidth(4)) i3 ();
  assign i4.en_i = en;
  assign i4.cfg_valid_i = cv;
  assign i4.cfg_idx_i = ci;
  assign i4.cfg_weight_i = cw;
  assign i4.mon_valid_i = mv;
  assign i4.mon_ready_i = mr;
  assign i4.mon_ini_i = mi4;
  assign i3.en_i = en;
  assign i3.cfg_valid_i = cv;
  assign i3.cfg_idx_i = ci;
  assign i3.cfg_weight_i = cw;
  assign i3.mon_valid_i = mv;
  assign i3.mon_ready_i = mr;
  assign i3.mon_ini_i = mi3;
  xbar_wrr_prio_ctrl #(.NumIn(4), .NumOut(4), .WeightWidth(4)) u4 (.clk_i(clk_i), .rst_ni(rst_ni), .bus(i4.slave));
  xbar_wrr_prio_ctrl #(.NumIn(3), .NumOut(4), .WeightWidth(4)) u3 (.clk_i(clk_i), .rst_ni(rst_ni), .bus(i3.slave));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int eff(input int w);
    return (w == 0) ? 1 : w;
  endfunction

  // Model: each target remembers who holds priority and how many grants remain before it moves on.
  task automatic tick();
    int np[2][4], nc[2][4], nw[2][4];
    for (int u = 0; u < 2; u++) begin
      int n = u ? 3 : 4;
      for (int k = 0; k < 4; k++) begin
        int g = u ? int'(mi3[k]) : int'(mi4[k]);
        int p = m_ptr[u][k];
        np[u][k] = p;
        nc[u][k] = m_cr[u][k];
        if (!rst_ni) begin
          np[u][k] = 0;
          nc[u][k] = 1;
        end else if (en && mv[k] && mr[k]) begin
          if (g == p) begin
            if (m_cr[u][k] > 1) nc[u][k] = m_cr[u][k] - 1;
            else begin
              np[u][k] = (p + 1) % n;
              nc[u][k] = eff(m_w[u][np[u][k]]);
            end
          end else if (eff(m_w[u][g]) > 1) begin
            np[u][k] = g;
            nc[u][k] = eff(m_w[u][g]) - 1;
          end else begin
            np[u][k] = (g + 1) % n;
            nc[u][k] = eff(m_w[u][np[u][k]]);
          end
        end
      end
      for (int i = 0; i < 4; i++) nw[u][i] = !rst_ni ? 1 : m_w[u][i];
      if (rst_ni && cv && int'(ci) < n) nw[u][ci] = int'(cw);
    end
    @(posedge clk_i);
    m_ptr = np;
    m_cr = nc;
    m_w = nw;
    #1;
  endtask

  always @(negedge clk_i) begin
    if (chk_on) begin
      for (int k = 0; k < 4; k++) begin
        chk("model_rr4", int'(i4.rr_o[k]), m_ptr[0][k]);
        chk("model_cr4", int'(i4.credit_o[k]), m_cr[0][k]);
        chk("model_rr3", int'(i3.rr_o[k]), m_ptr[1][k]);
        chk("model_cr3", int'(i3.credit_o[k]), m_cr[1][k]);
      end
    end
  end

  task automatic idle();
    en = 1; cv = 0; ci = 0; cw = 0; mv = 0; mr = 0; mi4 = '0; mi3 = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_ni = 0;
    tick();
    rst_ni = 1;
  endtask

  task automatic cfg(input int i, input int w);
    cv = 1; ci = 2'(i); cw = 4'(w);
    tick();
    cv = 0;
  endtask

  task automatic grant(input int k, input int g);
    mv[k] = 1; mr[k] = 1; mi4[k] = 2'(g);
    tick();
    mv[k] = 0; mr[k] = 0; mi4[k] = 0;
  endtask

  initial begin
    int rr_seq[5] = '{1, 2, 3, 0, 1};
    int w_hold[7] = '{0, 0, 0, 1, 2, 2, 3};
    int w_rr[8] = '{0, 0, 0, 1, 2, 2, 3, 0};
    int w_cr[8] = '{3, 2, 1, 1, 2, 1, 1, 3};
    int wrap[3] = '{1, 2, 0};
    idle();
    rst_ni = 0;
    for (int c = 0; c < 3; c++) begin
      mv = 4'($urandom); mr = 4'($urandom);
      for (int k = 0; k < 4; k++) begin
        mi4[k] = 2'($urandom_range(0, 3));
        mi3[k] = 2'($urandom_range(0, 2));
      end
      tick();
    end
    chk_on = 1;
    for (int k = 0; k < 4; k++) begin
      chk("reset_rr4", int'(i4.rr_o[k]), 0);
      chk("reset_cr4", int'(i4.credit_o[k]), 1);
      chk("reset_rr3", int'(i3.rr_o[k]), 0);
      chk("reset_cr3", int'(i3.credit_o[k]), 1);
    end
    rst_ni = 1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      grant(0, (i == 4) ? 0 : i);
      chk("default_rr", int'(i4.rr_o[0]), rr_seq[i]);
    end
    do_reset();
    cfg(0, 3); cfg(1, 1); cfg(2, 2); cfg(3, 1);
    grant(1, 3);
    chk("wrr_rr", int'(i4.rr_o[1]), w_rr[0]);
    chk("wrr_cr", int'(i4.credit_o[1]), w_cr[0]);
    for (int i = 0; i < 7; i++) begin
      grant(1, w_hold[i]);
      chk("wrr_rr", int'(i4.rr_o[1]), w_rr[i + 1]);
      chk("wrr_cr", int'(i4.credit_o[1]), w_cr[i + 1]);
    end
    do_reset();
    cfg(3, 2);
    grant(2, 0); grant(2, 1);
    chk("skip_pre", int'(i4.rr_o[2]), 2);
    grant(2, 3);
    chk("skip_rr", int'(i4.rr_o[2]), 3);
    chk("skip_cr", int'(i4.credit_o[2]), 1);
    do_reset();
    cfg(3, 0); cfg(0, 4);
    grant(2, 0); grant(2, 1); grant(2, 3);
    chk("skip0_rr", int'(i4.rr_o[2]), 0);
    chk("skip0_cr", int'(i4.credit_o[2]), 4);
    do_reset();
    cv = 1; ci = 1; cw = 5; mv[3] = 1; mr[3] = 1; mi4[3] = 0;
    tick();
    idle();
    chk("race_rr", int'(i4.rr_o[3]), 1);
    chk("race_cr", int'(i4.credit_o[3]), 1);
    grant(3, 1); grant(3, 2); grant(3, 3); grant(3, 0);
    chk("race_reload_rr", int'(i4.rr_o[3]), 1);
    chk("race_reload_cr", int'(i4.credit_o[3]), 5);
    en = 0; mv = '1; mr = '1;
    for (int c = 0; c < 10; c++) begin
      for (int k = 0; k < 4; k++) begin
        mi4[k] = 2'($urandom_range(0, 3));
        mi3[k] = 2'($urandom_range(0, 2));
      end
      tick();
    end
    chk("en0_rr", int'(i4.rr_o[3]), 1);
    chk("en0_cr", int'(i4.credit_o[3]), 5);
    do_reset();
    mv = '1; mr = '1;
    tick();
    idle();
    for (int k = 0; k < 4; k++) begin
      chk("simul_rr4", int'(i4.rr_o[k]), 1);
      chk("simul_rr3", int'(i3.rr_o[k]), 1);
    end
    do_reset();
    for (int i = 0; i < 3; i++) begin
      mv[0] = 1; mr[0] = 1; mi3[0] = 2'(i); mi4[0] = 2'(i);
      tick();
      chk("wrap3_rr", int'(i3.rr_o[0]), wrap[i]);
    end
    idle();
    for (int c = 0; c < 4000; c++) begin
      rst_ni = ($urandom_range(0, 199) != 0);
      en = ($urandom_range(0, 7) != 0);
      cv = ($urandom_range(0, 3) == 0);
      ci = 2'($urandom); cw = 4'($urandom);
      mv = 4'($urandom); mr = 4'($urandom);
      for (int k = 0; k < 4; k++) begin
        mi4[k] = 2'($urandom_range(0, 3));
        mi3[k] = 2'($urandom_range(0, 2));
      end
      tick();
    end
    @(negedge clk_i);
    chk_on = 0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
